// File: rtl/qsys_led_sequencer.sv
// LED pattern sequencer: steps through a 2-bit pattern table and writes each step to an Avalon-MM LED PIO.
// Latency: first write one cycle after enable is sampled, then one write every max(period,1) cycles.
// Backpressure: none from the bus; a software override wins arbitration and delays a colliding sequencer write by one cycle.
// Optional feature: define LED_SEQ_SW_OVERRIDE_EN to build the software override path (SW_WR state, pending flag).
module qsys_led_sequencer #(
  parameter int CNT_W = 24,
  parameter int STEPS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [CNT_W-1:0]   period,
  input  logic [2*STEPS-1:0] pattern,
  input  logic               sw_req,
  input  logic [1:0]         sw_mode,
  input  logic [1:0]         sw_data,
  output logic               sw_ack,
  output logic               m_chipselect,
  output logic               m_write_n,
  output logic [2:0]         m_address,
  output logic [31:0]        m_writedata,
  output logic [3:0]         step_idx,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    SEQ_WR = 2'd2
`ifdef LED_SEQ_SW_OVERRIDE_EN
    ,
    SW_WR  = 2'd3
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] load_val;
  logic [3:0]       idx_q, idx_d, idx_nxt;
  logic [3:0]       step_idx_q, step_idx_d;
  logic             tc;

`ifdef LED_SEQ_SW_OVERRIDE_EN
  logic             pend_q, pend_d;
  logic [2:0]       sw_addr_q, sw_addr_d;
  logic [1:0]       sw_dat_q, sw_dat_d;
  logic [2:0]       sw_addr_sel;
`else
  logic             sw_unused;
  assign sw_unused = ^{sw_req, sw_mode, sw_data};
`endif

  // Next-state logic: counter runs in COUNT and SW_WR so an override never shifts sequencer timing
  // unless it lands exactly on the terminal count, in which case the pending flag forces SEQ_WR next.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    step_idx_d = step_idx_q;
`ifdef LED_SEQ_SW_OVERRIDE_EN
    pend_d      = pend_q;
    sw_addr_d   = sw_addr_q;
    sw_dat_d    = sw_dat_q;
    sw_addr_sel = 3'd0;
    case (sw_mode)
      2'd1:    sw_addr_sel = 3'd4;
      2'd2:    sw_addr_sel = 3'd5;
      default: sw_addr_sel = 3'd0;
    endcase
`endif
    load_val = (period == '0) ? '0 : period - CNT_W'(1);
    tc       = (cnt_q <= CNT_W'(1));
    idx_nxt  = (idx_q == 4'(STEPS - 1)) ? 4'd0 : idx_q + 4'd1;

    case (state_q)
      IDLE: begin
`ifdef LED_SEQ_SW_OVERRIDE_EN
        if (sw_req) begin
          state_d   = SW_WR;
          sw_addr_d = sw_addr_sel;
          sw_dat_d  = sw_data;
          pend_d    = enable;
        end else
`endif
        if (enable) begin
          state_d = SEQ_WR;
          idx_d   = 4'd0;
        end
      end

      SEQ_WR: begin
        step_idx_d = idx_q;
        idx_d      = idx_nxt;
        cnt_d      = load_val;
`ifdef LED_SEQ_SW_OVERRIDE_EN
        if (sw_req) begin
          state_d   = SW_WR;
          sw_addr_d = sw_addr_sel;
          sw_dat_d  = sw_data;
          pend_d    = (load_val == '0);
        end else
`endif
        if (load_val == '0) begin
          state_d = SEQ_WR;
        end else begin
          state_d = COUNT;
        end
      end

      COUNT: begin
`ifdef LED_SEQ_SW_OVERRIDE_EN
        if (sw_req) begin
          state_d   = SW_WR;
          sw_addr_d = sw_addr_sel;
          sw_dat_d  = sw_data;
          if (tc) begin
            pend_d = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end else
`endif
        if (tc) begin
          state_d = SEQ_WR;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

`ifdef LED_SEQ_SW_OVERRIDE_EN
      SW_WR: begin
        pend_d = 1'b0;
        if (pend_q || tc) begin
          state_d = SEQ_WR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (sw_req) begin
            state_d   = SW_WR;
            sw_addr_d = sw_addr_sel;
            sw_dat_d  = sw_data;
          end else begin
            state_d = COUNT;
          end
        end
      end
`endif

      default: state_d = IDLE;
    endcase

    // Dropping enable stops the sequence after the current cycle; a write already on the bus completes.
    if (!enable && (state_q != IDLE)) begin
      state_d    = IDLE;
      cnt_d      = '0;
      idx_d      = 4'd0;
      step_idx_d = 4'd0;
`ifdef LED_SEQ_SW_OVERRIDE_EN
      pend_d     = 1'b0;
`endif
    end
  end

  // State register with asynchronous reset so the bus strobe drops immediately on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= 4'd0;
      step_idx_q <= 4'd0;
`ifdef LED_SEQ_SW_OVERRIDE_EN
      pend_q     <= 1'b0;
      sw_addr_q  <= 3'd0;
      sw_dat_q   <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      step_idx_q <= step_idx_d;
`ifdef LED_SEQ_SW_OVERRIDE_EN
      pend_q     <= pend_d;
      sw_addr_q  <= sw_addr_d;
      sw_dat_q   <= sw_dat_d;
`endif
    end
  end

  // Bus outputs decoded from the state: a write is exactly the one cycle spent in a *_WR state.
  always_comb begin
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    m_address    = 3'd0;
    m_writedata  = 32'd0;
    sw_ack       = 1'b0;
    case (state_q)
      SEQ_WR: begin
        m_chipselect     = 1'b1;
        m_write_n        = 1'b0;
        m_writedata[1:0] = pattern[{idx_q, 1'b0} +: 2];
      end
`ifdef LED_SEQ_SW_OVERRIDE_EN
      SW_WR: begin
        m_chipselect     = 1'b1;
        m_write_n        = 1'b0;
        m_address        = sw_addr_q;
        m_writedata[1:0] = sw_dat_q;
        sw_ack           = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign step_idx = step_idx_q;

endmodule
